// File: rtl/msx_bus_cycle_engine_if.sv
// Host request/response handshake plus MSX slot pins, bundled for the bus cycle engine.
// master: the engine side (drives strobes, address, data and responses).
// slave: the host and slot side (drives requests, D_IN and WAIT_n).
interface msx_bus_cycle_engine_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int NSLOT  = 2
);
  logic              REQ_VALID;
  logic              REQ_READY;
  logic [ADDR_W-1:0] REQ_ADDR;
  logic [DATA_W-1:0] REQ_WDATA;
  logic              REQ_WR;
  logic              REQ_IO;
  logic [1:0]        REQ_SLOT;
  logic              RSP_VALID;
  logic [DATA_W-1:0] RSP_RDATA;
  logic              RSP_ERR;
  logic              MSX_CLK;
  logic [ADDR_W-1:0] A;
  logic [DATA_W-1:0] D_OUT;
  logic              D_OE;
  logic [DATA_W-1:0] D_IN;
  logic              MREQ_n;
  logic              IORQ_n;
  logic              RD_n;
  logic              WR_n;
  logic [NSLOT-1:0]  SLTSL_n;
  logic              CS1_n;
  logic              CS2_n;
  logic              CS12_n;
  logic              WAIT_n;

  modport master (
    input  REQ_VALID, REQ_ADDR, REQ_WDATA, REQ_WR, REQ_IO, REQ_SLOT, D_IN, WAIT_n,
    output REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR, MSX_CLK, A, D_OUT, D_OE,
    output MREQ_n, IORQ_n, RD_n, WR_n, SLTSL_n, CS1_n, CS2_n, CS12_n
  );

  modport slave (
    output REQ_VALID, REQ_ADDR, REQ_WDATA, REQ_WR, REQ_IO, REQ_SLOT, D_IN, WAIT_n,
    input  REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR, MSX_CLK, A, D_OUT, D_OE,
    input  MREQ_n, IORQ_n, RD_n, WR_n, SLTSL_n, CS1_n, CS2_n, CS12_n
  );
endinterface

// File: rtl/msx_bus_cycle_engine.sv
// MSX cartridge-bus master: one host request -> one Z80-style memory/I/O cycle with WAIT_n and timeout.
// Latency: accept to RSP_VALID = 3 T-states (+TW) + up to one MSX period alignment + 1 CLK.
// Backpressure: REQ_READY low from accept until the CLK after RSP_VALID; no queuing.
module msx_bus_cycle_engine #(
  parameter int ADDR_W  = 16,   // decode uses A[15:14], so ADDR_W >= 16
  parameter int DATA_W  = 8,
  parameter int NSLOT   = 2,
  parameter int CLK_DIV = 8,
  parameter int TMO_T   = 1023
) (
  input logic CLK,
  input logic RST,
  msx_bus_cycle_engine_if.master bus
);
  localparam int DIV_W  = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int WCNT_W = (TMO_T > 1) ? $clog2(TMO_T + 1) : 1;
  localparam bit TMO_EN = (TMO_T != 0);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PEND = 3'd1;  // accepted, waiting for TICK alignment
  localparam logic [2:0] S_T1   = 3'd2;
  localparam logic [2:0] S_T2   = 3'd3;
  localparam logic [2:0] S_TW   = 3'd4;
  localparam logic [2:0] S_T3   = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  logic [DIV_W-1:0]  div_q, div_d;
  logic              msx_clk_q, msx_clk_d, tick;
  logic              wait_s1_q, wait_s2_q;
  logic [2:0]        state_q, state_d;
  logic              ready_q, accept;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              wr_q, io_q;
  logic [1:0]        slot_q;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d, wcnt_inc;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              d_oe_q, d_oe_d, strb, mem_sel, cs1, cs2;
  logic              mreq_n_q, iorq_n_q, rd_n_q, wr_n_q, cs1_n_q, cs2_n_q, cs12_n_q;
  logic [NSLOT-1:0]  sltsl_n_q, sltsl_n_d;

  assign tick      = (div_q == DIV_W'(CLK_DIV - 1));
  assign div_d     = tick ? '0 : div_q + 1'b1;
  // first half of the period low, second half high; TICK lands on the last high CLK
  assign msx_clk_d = (div_d >= DIV_W'(CLK_DIV / 2));
  assign accept    = (state_q == S_IDLE) && ready_q && bus.REQ_VALID;
  assign wcnt_inc  = wcnt_q + 1'b1;

  // MSX clock divider, free-running from reset
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      div_q     <= '0;
      msx_clk_q <= 1'b0;
    end else begin
      div_q     <= div_d;
      msx_clk_q <= msx_clk_d;
    end
  end

  // two-flop synchroniser for the asynchronous WAIT_n pin; idles released
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wait_s1_q <= 1'b1;
      wait_s2_q <= 1'b1;
    end else begin
      wait_s1_q <= bus.WAIT_n;
      wait_s2_q <= wait_s1_q;
    end
  end

  // capture the whole request at the handshake so the host may change it afterwards
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      io_q    <= 1'b0;
      slot_q  <= 2'd0;
    end else if (accept) begin
      addr_q  <= bus.REQ_ADDR;
      wdata_q <= bus.REQ_WDATA;
      wr_q    <= bus.REQ_WR;
      io_q    <= bus.REQ_IO;
      slot_q  <= bus.REQ_SLOT;
    end
  end

  // cycle sequencing: every bus-phase change waits for TICK, DONE lasts one CLK
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: if (accept) state_d = S_PEND;
      S_PEND: if (tick) state_d = S_T1;
      S_T1:   if (tick) begin
                state_d = S_T2;
                wcnt_d  = '0;
              end
      S_T2:   if (tick) state_d = wait_s2_q ? S_T3 : S_TW;
      S_TW:   if (tick) begin
                wcnt_d = wcnt_inc;
                // timeout is checked before WAIT_n release so it wins a tie
                if (TMO_EN && (wcnt_inc == WCNT_W'(TMO_T))) begin
                  state_d = S_DONE;
                  err_d   = 1'b1;
                  rdata_d = '1;
                end else if (wait_s2_q) begin
                  state_d = S_T3;
                end
              end
      S_T3:   if (tick) begin
                state_d = S_DONE;
                err_d   = 1'b0;
                rdata_d = wr_q ? '0 : bus.D_IN;
              end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // bus pin values follow the state being entered so they change exactly on TICK
  always_comb begin
    strb    = (state_d == S_T2) || (state_d == S_TW) || (state_d == S_T3);
    mem_sel = strb && !io_q;
    cs1     = mem_sel && (addr_q[15:14] == 2'b01);
    cs2     = mem_sel && (addr_q[15:14] == 2'b10);
    d_oe_d  = wr_q && (strb || (state_d == S_T1));
    a_d     = (state_d == S_T1) ? addr_q : a_q;
    dout_d  = (state_d == S_T1) ? wdata_q : dout_q;
    sltsl_n_d = '1;
    for (int i = 0; i < NSLOT; i++) begin
      if (mem_sel && (slot_q == 2'(i))) sltsl_n_d[i] = 1'b0;
    end
  end

  // FSM, handshake and response registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      ready_q     <= 1'b0;
      wcnt_q      <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_q     <= (state_d == S_IDLE);
      wcnt_q      <= wcnt_d;
      rsp_valid_q <= (state_d == S_DONE);
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  // registered slot pins so strobes and selects never glitch
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      a_q       <= '0;
      dout_q    <= '0;
      d_oe_q    <= 1'b0;
      mreq_n_q  <= 1'b1;
      iorq_n_q  <= 1'b1;
      rd_n_q    <= 1'b1;
      wr_n_q    <= 1'b1;
      sltsl_n_q <= '1;
      cs1_n_q   <= 1'b1;
      cs2_n_q   <= 1'b1;
      cs12_n_q  <= 1'b1;
    end else begin
      a_q       <= a_d;
      dout_q    <= dout_d;
      d_oe_q    <= d_oe_d;
      mreq_n_q  <= !(strb && !io_q);
      iorq_n_q  <= !(strb && io_q);
      rd_n_q    <= !(strb && !wr_q);
      wr_n_q    <= !(strb && wr_q);
      sltsl_n_q <= sltsl_n_d;
      cs1_n_q   <= !cs1;
      cs2_n_q   <= !cs2;
      cs12_n_q  <= !(cs1 || cs2);
    end
  end

  assign bus.REQ_READY = ready_q;
  assign bus.RSP_VALID = rsp_valid_q;
  assign bus.RSP_RDATA = rdata_q;
  assign bus.RSP_ERR   = err_q;
  assign bus.MSX_CLK   = msx_clk_q;
  assign bus.A         = a_q;
  assign bus.D_OUT     = dout_q;
  assign bus.D_OE      = d_oe_q;
  assign bus.MREQ_n    = mreq_n_q;
  assign bus.IORQ_n    = iorq_n_q;
  assign bus.RD_n      = rd_n_q;
  assign bus.WR_n      = wr_n_q;
  assign bus.SLTSL_n   = sltsl_n_q;
  assign bus.CS1_n     = cs1_n_q;
  assign bus.CS2_n     = cs2_n_q;
  assign bus.CS12_n    = cs12_n_q;
endmodule
